// File: rtl/weight_stream_writer.sv
// weight_stream_writer
//   Parses a framed byte stream (A5h | id | LEN[23:16] | LEN[15:8] | LEN[7:0] | payload | CHK)
//   and emits one registered weight-memory write per payload byte. CHK is the XOR of the payload.
//   Optional macro WEIGHT_STREAM_ORDER_CHECK_EN: frames must arrive with layer ids 0..NUM_LAYERS-1
//   in order, otherwise the parser stops with error code 4.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               arm/re-arm pulse; clears done/error
//   s_valid/s_data      stream byte in; s_ready out (transfer = s_valid & s_ready)
//   wr_en/wr_layer/wr_addr/wr_data  weight write, one cycle after the payload byte is accepted
//   busy, done, error, error_code   status (code: 1 id, 2 length, 3 checksum, 4 order)
module weight_stream_writer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned NUM_LAYERS      = 6,
  parameter int unsigned LAYER_SEL_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       wr_en,
  output logic [LAYER_SEL_WIDTH-1:0] wr_layer,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 error_code
);

  localparam int unsigned LEN_W  = 3 * DATA_WIDTH;
  localparam int unsigned LEN_XW = LEN_W + 1;
  localparam logic [LEN_XW-1:0] MAX_LEN = LEN_XW'(1) << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'hA5);

  typedef enum logic [3:0] {
    IDLE, SYNC, HDR_ID, HDR_L2, HDR_L1, HDR_L0, PAYLOAD, CHECK, DONE, ERR
  } state_e;

  state_e                     state_q, state_d;
  logic [LAYER_SEL_WIDTH-1:0] id_q, id_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      chk_q, chk_d;
  logic [2:0]                 code_q, code_d;
  logic                       wr_en_d;
  logic [LAYER_SEL_WIDTH-1:0] wr_layer_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_d;
  logic                       s_ready_d, busy_d, done_d, error_d;
  logic                       acc;
  logic [LEN_W-1:0]           len_shift;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
  logic [LAYER_SEL_WIDTH-1:0] exp_q, exp_d;
`endif

  assign acc       = s_valid & s_ready;
  assign len_shift = LEN_W'({len_q, s_data});

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    chk_d      = chk_q;
    code_d     = code_q;
    wr_en_d    = 1'b0;
    wr_layer_d = wr_layer;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
    exp_d      = exp_q;
`endif
    if (start) begin
      // start wins over a same-cycle byte, which is dropped
      state_d = SYNC;
      code_d  = 3'd0;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
      exp_d   = '0;
`endif
    end else if (acc) begin
      unique case (state_q)
        SYNC: if (s_data == SYNC_BYTE) state_d = HDR_ID;
        HDR_ID: begin
          if (32'(s_data) >= NUM_LAYERS) begin
            state_d = ERR;
            code_d  = 3'd1;
          end else begin
            id_d    = LAYER_SEL_WIDTH'(s_data);
            state_d = HDR_L2;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
            if (LAYER_SEL_WIDTH'(s_data) != exp_q) begin
              state_d = ERR;
              code_d  = 3'd4;
            end
`endif
          end
        end
        HDR_L2: begin
          len_d   = len_shift;
          state_d = HDR_L1;
        end
        HDR_L1: begin
          len_d   = len_shift;
          state_d = HDR_L0;
        end
        HDR_L0: begin
          len_d = len_shift;
          if (len_shift == '0 || {1'b0, len_shift} > MAX_LEN) begin
            state_d = ERR;
            code_d  = 3'd2;
          end else begin
            cnt_d   = '0;
            chk_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en_d    = 1'b1;
          wr_layer_d = id_q;
          wr_addr_d  = ADDR_WIDTH'(cnt_q);
          wr_data_d  = s_data;
          cnt_d      = cnt_q + LEN_W'(1);
          chk_d      = chk_q ^ s_data;
          if (cnt_q == len_q - LEN_W'(1)) state_d = CHECK;
        end
        CHECK: begin
          if (s_data != chk_q) begin
            state_d = ERR;
            code_d  = 3'd3;
          end else begin
            state_d = (32'(id_q) == NUM_LAYERS - 1) ? DONE : SYNC;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
            exp_d   = exp_q + LAYER_SEL_WIDTH'(1);
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
    // Status outputs track the state being entered so they change with it
    s_ready_d = state_d inside {SYNC, HDR_ID, HDR_L2, HDR_L1, HDR_L0, PAYLOAD, CHECK};
    busy_d    = s_ready_d;
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      chk_q    <= '0;
      code_q   <= '0;
      wr_en    <= 1'b0;
      wr_layer <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
      exp_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      chk_q    <= chk_d;
      code_q   <= code_d;
      wr_en    <= wr_en_d;
      wr_layer <= wr_layer_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      s_ready  <= s_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
`ifdef WEIGHT_STREAM_ORDER_CHECK_EN
      exp_q    <= exp_d;
`endif
    end
  end

  assign error_code = code_q;

endmodule
